// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PCF, imem req/ack handshake, redirect and bubbles.
// Optional FETCH_PERF_CNT_EN adds handoff/drop counters on fetch_cnt/drop_cnt.
module fetch_stage #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [31:0]     fetch_cnt,
    output logic [15:0]     drop_cnt
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_HOLD,
        S_DROP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] stale_pc;
    logic [XLEN-1:0] buf_instr;
    logic [XLEN-1:0] src_instr;
    logic            ack;
    logic            avail;
    logic            handoff;
    logic            load;

    // An ack only completes a transfer while a request is actually up
    assign ack       = imem_ack & imem_req;
    assign avail     = ((state == S_REQ) & ack) | (state == S_HOLD);
    assign handoff   = avail & ~StallD & ~StallF;
    assign load      = handoff & ~PCSrcE;
    assign src_instr = (state == S_HOLD) ? buf_instr : imem_rdata;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: redirect beats handoff; unacked redirect waits out the stale fetch
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT: state_nxt = S_REQ;
            S_REQ: begin
                if (PCSrcE) begin
                    state_nxt = ack ? S_REQ : S_DROP;
                end else if (ack && !handoff) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (PCSrcE || handoff) begin
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (ack) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    // Outputs: request held at the stale address while draining a dropped fetch
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pcf;
        unique case (state)
            S_REQ:  imem_req = 1'b1;
            S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = stale_pc;
            end
            default: imem_req = 1'b0;
        endcase
    end

    // Next PC: redirect target, else advance on each handoff
    always_comb begin
        pc_nxt = pcf;
        if (state != S_BOOT && PCSrcE) begin
            pc_nxt = PCTargetE;
        end else if (load) begin
            pc_nxt = pcf + STEP;
        end
    end

    // PCF, stale request address and the stalled-instruction buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcf       <= RESET_PC;
            stale_pc  <= RESET_PC;
            buf_instr <= '0;
        end else begin
            pcf <= pc_nxt;
            if (state == S_REQ && PCSrcE && !ack) begin
                stale_pc <= pcf;
            end
            if (state == S_REQ && ack && !handoff && !PCSrcE) begin
                buf_instr <= imem_rdata;
            end
        end
    end

    // IF/ID register: flush > stall > load > bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            ValidD   <= ValidD;
        end else if (load) begin
            InstrD   <= src_instr;
            PCD      <= pcf;
            PCPlus4D <= pcf + STEP;
            ValidD   <= 1'b1;
        end else begin
            InstrD   <= '0;
            ValidD   <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic drop;

    // A discarded ack or a buffered instruction thrown away by redirect
    assign drop = (PCSrcE & (((state == S_REQ) & ack) | (state == S_HOLD)))
                | ((state == S_DROP) & ack);

    // Free-running wrap-around performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (load) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (drop) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`else
    assign fetch_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable imem model
// and a scoreboard of fetched (pc, instr) pairs.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] fetch_cnt;
    logic [15:0] drop_cnt;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   lat = 0;
    int   wait_cnt = 0;
    int   exp_fetch = 0;
    int   exp_drop = 0;
    bit   sb_skip = 1'b0;
    bit   force_ack = 1'b0;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .fetch_cnt(fetch_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h4) return 32'hE3A01005;
        return a ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef FETCH_PERF_CNT_EN
        return 32'(v);
`else
        return (v == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (force_ack) begin
            imem_ack = 1'b1;
        end else if (imem_req) begin
            if (wait_cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem(imem_addr);
                wait_cnt   = 0;
                if (PCSrcE || sb_skip) begin
                    exp_drop++;
                    sb_skip = 1'b0;
                end else begin
                    e.pc    = imem_addr;
                    e.instr = mem(imem_addr);
                    sb.push_back(e);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        @(posedge clk);
        #1;
        if (!StallD && !FlushD && ValidD) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_instr", InstrD, e.instr);
                chk("sb_pcd", PCD, e.pc);
                chk("sb_pcplus4", PCPlus4D, e.pc + 32'd4);
                exp_fetch++;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(ValidD), 32'd0);
        chk("rst_instr", InstrD, 32'h0);
        chk("rst_pcd", PCD, 32'h0);
        chk("rst_pc4", PCPlus4D, 32'h0);
        chk("rst_fcnt", fetch_cnt, 32'h0);
        chk("rst_dcnt", 32'(drop_cnt), 32'h0);
        sb.delete();
        wait_cnt = 0; exp_fetch = 0; exp_drop = 0; sb_skip = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("boot_req", 32'(imem_req), 32'd0);
        chk("boot_addr", imem_addr, 32'h0);
    endtask

    initial begin
        // zero-wait memory: PCD 0,4,8 back to back
        lat = 0;
        do_reset();
        step();
        chk("zw_boot_valid", 32'(ValidD), 32'd0);
        step(); chk("zw_pcd0", PCD, 32'h0); chk("zw_v0", 32'(ValidD), 32'd1);
        step(); chk("zw_pcd4", PCD, 32'h4); chk("zw_v4", 32'(ValidD), 32'd1);
        step(); chk("zw_pcd8", PCD, 32'h8); chk("zw_v8", 32'(ValidD), 32'd1);

        // three-cycle memory: three bubbles with a stable address
        lat = 3;
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("slow_bubble_valid", 32'(ValidD), 32'd0);
            chk("slow_bubble_instr", InstrD, 32'h0);
            chk("slow_addr_stable", imem_addr, 32'h0);
            chk("slow_req_up", 32'(imem_req), 32'd1);
        end
        step();
        chk("slow_pcd0", PCD, 32'h0);
        chk("slow_valid", 32'(ValidD), 32'd1);

        // StallD across the ack: buffered, request dropped, then handed off
        lat = 0;
        StallD = 1'b1;
        step();
        chk("stall_hold_req0", 32'(imem_req), 32'd0);
        chk("stall_pcd_held", PCD, 32'h0);
        step();
        chk("stall_hold_req1", 32'(imem_req), 32'd0);
        chk("stall_pcd_held2", PCD, 32'h0);
        StallD = 1'b0;
        step();
        chk("stall_instr", InstrD, 32'hE3A01005);
        chk("stall_pcd", PCD, 32'h4);
        chk("stall_valid", 32'(ValidD), 32'd1);

        // redirect while the fetch at 0x8 is still pending
        lat = 2;
        PCSrcE = 1'b1;
        PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        chk("drop_addr_stale", imem_addr, 32'h8);
        chk("drop_bubble", 32'(ValidD), 32'd0);
        sb_skip = 1'b1;
        step();
        chk("drop_addr_stale2", imem_addr, 32'h8);
        step();
        chk("drop_cnt1", 32'(drop_cnt), cnt_exp(exp_drop));
        chk("drop_next_addr", imem_addr, 32'h100);
        chk("drop_valid", 32'(ValidD), 32'd0);
        lat = 0;
        step();
        chk("redir_pcd", PCD, 32'h100);

        // redirect in the same cycle as an ack
        PCSrcE = 1'b1;
        PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0;
        chk("redir_ack_bubble", 32'(ValidD), 32'd0);
        chk("redir_ack_addr", imem_addr, 32'h200);
        chk("redir_ack_dcnt", 32'(drop_cnt), cnt_exp(exp_drop));
        step();
        chk("redir_ack_pcd", PCD, 32'h200);

        // FlushD beats StallD
        FlushD = 1'b1;
        StallD = 1'b1;
        step();
        chk("flush_valid", 32'(ValidD), 32'd0);
        chk("flush_instr", InstrD, 32'h0);
        chk("flush_pcd", PCD, 32'h0);
        FlushD = 1'b0;
        StallD = 1'b0;
        step();
        chk("flush_after_pcd", PCD, 32'h204);

        // PC wraps at the top of the address space
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        step();
        PCSrcE = 1'b0;
        step();
        chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
        chk("wrap_pc4", PCPlus4D, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        step();
        chk("wrap_pcd0", PCD, 32'h0);
        chk("fetch_cnt", fetch_cnt, cnt_exp(exp_fetch));
        chk("drop_cnt", 32'(drop_cnt), cnt_exp(exp_drop));

        // drain: nothing left in flight
        lat = 1000;
        step();
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // reset mid-request; a stray ack during boot is ignored
        chk("pre_reset_req", 32'(imem_req), 32'd1);
        do_reset();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        chk("stray_ack_valid", 32'(ValidD), 32'd0);
        chk("post_reset_addr", imem_addr, 32'h0);
        lat = 0;
        step();
        chk("post_reset_pcd", PCD, 32'h0);
        chk("post_reset_valid", 32'(ValidD), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
